// File: rtl/button_mode_ctrl.sv
// -----------------------------------------------------------------------------
// button_mode_ctrl
// Conditions the five board push-buttons: two-flop synchronisation, per-button
// debounce, rising-edge pulse generation. A sticky display-mode register
// selects the dashboard view. The debounced centre button doubles as the
// CPU reset.
//
// Ports
//   clk           system clock
//   reset         asynchronous, active-high reset
//   btn_raw[4:0]  raw buttons {BTNC,BTNU,BTND,BTNL,BTNR}
//   btn_level     debounced button levels, same bit order
//   btn_press     one-cycle pulse on each debounced 0->1 transition
//   mode          display mode: 00 ordinary, 01 memory, 10 PC, 11 statistics
//   mode_changed  one-cycle pulse in the first cycle mode shows a new value
//   cpu_reset     debounced BTNC level
// -----------------------------------------------------------------------------
module button_mode_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_WIDTH       = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] btn_raw,
    output logic [4:0] btn_level,
    output logic [4:0] btn_press,
    output logic [1:0] mode,
    output logic       mode_changed,
    output logic       cpu_reset
);

    localparam int unsigned NUM_BTN = 5;
    localparam int unsigned BTN_C   = 4;
    localparam int unsigned BTN_U   = 3;
    localparam int unsigned BTN_D   = 2;
    localparam int unsigned BTN_L   = 1;
    localparam int unsigned BTN_R   = 0;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        MODE_ORD  = 2'b00,
        MODE_MEM  = 2'b01,
        MODE_PC   = 2'b10,
        MODE_STAT = 2'b11
    } mode_e;

    logic [NUM_BTN-1:0]   sync1;
    logic [NUM_BTN-1:0]   sync2;
    logic [CNT_WIDTH-1:0] cnt     [NUM_BTN];
    logic [CNT_WIDTH-1:0] cnt_nxt [NUM_BTN];
    logic [NUM_BTN-1:0]   level_nxt;
    logic [NUM_BTN-1:0]   press_nxt;
    logic                 c_override;
    mode_e                state;
    mode_e                state_nxt;

    // Two-flop synchroniser on the raw inputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    // Debounce next-state: count consecutive disagreeing cycles and commit
    // the new level once the count reaches DEBOUNCE_CYCLES-1. Any agreement
    // clears the count, so partial counts never survive a glitch.
    always_comb begin
        level_nxt = btn_level;
        for (int i = 0; i < NUM_BTN; i++) begin
            cnt_nxt[i] = '0;
            if (sync2[i] != btn_level[i]) begin
                if (cnt[i] >= CNT_MAX) begin
                    level_nxt[i] = sync2[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + CNT_ONE;
                end
            end
        end
        // Press pulse lines up with the first cycle btn_level reads 1.
        press_nxt = level_nxt & ~btn_level;
    end

    // Debounce state, levels and press pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_BTN; i++) begin
                cnt[i] <= '0;
            end
            btn_level <= '0;
            btn_press <= '0;
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
            btn_level <= level_nxt;
            btn_press <= press_nxt;
        end
    end

    // Centre button held (or being committed this cycle) pins the mode to ORD.
    assign c_override = btn_level[BTN_C] | level_nxt[BTN_C];

    // Mode state register; mode_changed flags the first cycle of a new value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= MODE_ORD;
            mode_changed <= 1'b0;
        end else begin
            state        <= state_nxt;
            mode_changed <= (state_nxt != state);
        end
    end

    // Mode next-state: priority C > U > D > L > R, hold when nothing pressed.
    always_comb begin
        state_nxt = state;
        if (c_override) begin
            state_nxt = MODE_ORD;
        end else if (press_nxt[BTN_U]) begin
            state_nxt = MODE_ORD;
        end else if (press_nxt[BTN_D]) begin
            state_nxt = MODE_MEM;
        end else if (press_nxt[BTN_L]) begin
            state_nxt = MODE_PC;
        end else if (press_nxt[BTN_R]) begin
            state_nxt = MODE_STAT;
        end
    end

    assign mode      = state;
    assign cpu_reset = btn_level[BTN_C];

endmodule

// File: tb/tb_button_mode_ctrl.sv
// -----------------------------------------------------------------------------
// tb_button_mode_ctrl
// Scoreboard bench for button_mode_ctrl with DEBOUNCE_CYCLES = 4. Each
// stimulus step pushes the event it should cause (edge number, press vector,
// mode, mode_changed); a negedge monitor pops and compares every cycle in
// which the DUT shows a press pulse or a mode change.
// -----------------------------------------------------------------------------
module tb_button_mode_ctrl;

    localparam int unsigned DEB = 4;
    localparam int unsigned LAT = 2 + DEB;

    typedef struct {
        string      tag;
        int         edge_no;
        logic [4:0] press;
        logic [1:0] mode;
        logic       mchg;
    } ev_t;

    logic       clk;
    logic       reset;
    logic [4:0] btn_raw;
    logic [4:0] btn_level;
    logic [4:0] btn_press;
    logic [1:0] mode;
    logic       mode_changed;
    logic       cpu_reset;

    int  cyc;
    int  n_tests;
    int  n_fail;
    ev_t sb[$];

    button_mode_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .CNT_WIDTH      (20)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .mode        (mode),
        .mode_changed(mode_changed),
        .cpu_reset   (cpu_reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, cyc);
        end
    endtask

    // Monitor: every pulse cycle must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset && (|btn_press || mode_changed)) begin
            if (sb.size() == 0) begin
                chk("spurious_evt", 32'({btn_press, mode_changed}), 32'd0);
            end else begin
                ev_t e;
                e = sb.pop_front();
                chk({e.tag, "_edge"}, 32'(cyc), 32'(e.edge_no));
                chk({e.tag, "_press"}, 32'(btn_press), 32'(e.press));
                chk({e.tag, "_mode"}, 32'(mode), 32'(e.mode));
                chk({e.tag, "_mchg"}, 32'(mode_changed), 32'(e.mchg));
            end
        end
    end

    // Change the raw inputs just after a falling edge; next rising edge is cyc+1.
    task automatic drive(input logic [4:0] v);
        @(negedge clk);
        btn_raw = v;
    endtask

    task automatic expect_ev(input string tag, input logic [4:0] press,
                             input logic [1:0] md, input logic mchg);
        ev_t e;
        e.tag     = tag;
        e.edge_no = cyc + int'(LAT);
        e.press   = press;
        e.mode    = md;
        e.mchg    = mchg;
        sb.push_back(e);
    endtask

    task automatic wait_drain(input string tag);
        int budget;
        budget = 40;
        while (sb.size() != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        #1;
        if (sb.size() != 0) begin
            chk({tag, "_timeout"}, 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    // Press with an expected event, wait for it, then release and settle.
    task automatic press_release(input string tag, input logic [4:0] v,
                                 input logic [1:0] md, input logic mchg);
        drive(v);
        expect_ev(tag, v, md, mchg);
        wait_drain(tag);
        drive(5'b00000);
        repeat (LAT + 2) @(negedge clk);
    endtask

    initial begin
        cyc     = 0;
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        btn_raw = 5'b00000;
        repeat (3) @(negedge clk);

        chk("rst_level", 32'(btn_level), 32'd0);
        chk("rst_press", 32'(btn_press), 32'd0);
        chk("rst_mode", 32'(mode), 32'd0);
        chk("rst_mchg", 32'(mode_changed), 32'd0);
        chk("rst_cpu", 32'(cpu_reset), 32'd0);

        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // L press: level, pulse and mode change all at edge +6.
        drive(5'b00010);
        expect_ev("l_press", 5'b00010, 2'b10, 1'b1);
        wait_drain("l_press");
        chk("l_level", 32'(btn_level), 32'h02);
        drive(5'b00000);
        repeat (LAT + 2) @(negedge clk);
        chk("l_release_level", 32'(btn_level), 32'h00);
        chk("l_release_mode", 32'(mode), 32'h2);

        // Bounce on D: 1,0,1,0 then stable 1.
        drive(5'b00100);
        drive(5'b00000);
        drive(5'b00100);
        drive(5'b00000);
        drive(5'b00100);
        expect_ev("bounce", 5'b00100, 2'b01, 1'b1);
        wait_drain("bounce");
        drive(5'b00000);
        repeat (LAT + 2) @(negedge clk);

        // Go to STAT, then D,L,R together: D wins.
        press_release("r_to_stat", 5'b00001, 2'b11, 1'b1);
        press_release("simul", 5'b00111, 2'b01, 1'b1);

        // Override: R held in STAT, then C added.
        drive(5'b00001);
        expect_ev("ovr_r", 5'b00001, 2'b11, 1'b1);
        wait_drain("ovr_r");
        drive(5'b10001);
        expect_ev("ovr_c", 5'b10000, 2'b00, 1'b1);
        wait_drain("ovr_c");
        chk("ovr_cpu_reset", 32'(cpu_reset), 32'd1);
        drive(5'b10000);
        repeat (LAT + 2) @(negedge clk);
        drive(5'b10001);
        expect_ev("ovr_r_ignored", 5'b00001, 2'b00, 1'b0);
        wait_drain("ovr_r_ignored");
        drive(5'b00000);
        repeat (LAT + 2) @(negedge clk);
        chk("ovr_after_mode", 32'(mode), 32'h0);
        chk("ovr_after_cpu", 32'(cpu_reset), 32'd0);

        // Repeat press of the current mode's button.
        press_release("rep_first", 5'b00001, 2'b11, 1'b1);
        press_release("rep_again", 5'b00001, 2'b11, 1'b0);
        chk("rep_mode", 32'(mode), 32'h3);

        // Async reset mid-debounce of D, D still held afterwards.
        drive(5'b00100);
        repeat (4) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_level", 32'(btn_level), 32'd0);
        chk("arst_press", 32'(btn_press), 32'd0);
        chk("arst_mode", 32'(mode), 32'd0);
        chk("arst_mchg", 32'(mode_changed), 32'd0);
        chk("arst_cpu", 32'(cpu_reset), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        expect_ev("arst_fresh", 5'b00100, 2'b01, 1'b1);
        wait_drain("arst_fresh");
        drive(5'b00000);
        repeat (LAT + 2) @(negedge clk);
        chk("final_mode", 32'(mode), 32'h1);
        chk("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
